llc_mshr_table: RTL and testbench

Parametrised miss-status holding register table for the Spandex LLC pipeline, the generalised successor to the fixed-size MSHR used inside the LLC core. It tracks up to N_ENTRIES outstanding transactions: per-entry set, tag, way, requester ID and pending invalidation-ack count. It detects set conflicts for the input decoder and reports entries whose acks have all arrived through a ready/valid completion port. The LLC FSM drives it: allocate on miss or recall, decrement on each inv-ack, retire when the transaction closes.

---
 rtl/llc_mshr_table.sv | 145 ++++++++++++++
 tb/tb_llc_mshr_table.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_mshr_table.sv
// llc_mshr_table: LLC miss-status holding table (set conflict lookup, inv-ack tracking, completion port); optional LLC_MSHR_CONFLICT_BLOCK_EN refuses same-set allocations
module llc_mshr_table #(
  parameter int N_ENTRIES   = 4,
  parameter int SET_BITS    = 9,
  parameter int TAG_BITS    = 17,
  parameter int WAY_BITS    = 4,
  parameter int ID_BITS     = 4,
  parameter int INVACK_BITS = 4,
  localparam int IDX_W = $clog2(N_ENTRIES),
  localparam int CNT_W = $clog2(N_ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [SET_BITS-1:0]    alloc_set_i,
  input  logic [TAG_BITS-1:0]    alloc_tag_i,
  input  logic [WAY_BITS-1:0]    alloc_way_i,
  input  logic [ID_BITS-1:0]     alloc_req_id_i,
  input  logic [INVACK_BITS-1:0] alloc_invack_cnt_i,
  output logic [IDX_W-1:0]       alloc_idx_o,
  input  logic [SET_BITS-1:0]    lookup_set_i,
  output logic                   lookup_hit_o,
  output logic [IDX_W-1:0]       lookup_idx_o,
  input  logic                   invack_valid_i,
  input  logic [IDX_W-1:0]       invack_idx_i,
  input  logic                   retire_valid_i,
  input  logic [IDX_W-1:0]       retire_idx_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic [IDX_W-1:0]       done_idx_o,
  output logic [ID_BITS-1:0]     done_req_id_o,
  output logic [WAY_BITS-1:0]    done_way_o,
  output logic [CNT_W-1:0]       mshr_cnt_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);
  logic [N_ENTRIES-1:0]   valid_q, valid_d, rep_q, rep_d;
  logic [SET_BITS-1:0]    set_q [N_ENTRIES];
  logic [SET_BITS-1:0]    set_d [N_ENTRIES];
  logic [TAG_BITS-1:0]    tag_q [N_ENTRIES];
  logic [TAG_BITS-1:0]    tag_d [N_ENTRIES];
  logic [WAY_BITS-1:0]    way_q [N_ENTRIES];
  logic [WAY_BITS-1:0]    way_d [N_ENTRIES];
  logic [ID_BITS-1:0]     id_q  [N_ENTRIES];
  logic [ID_BITS-1:0]     id_d  [N_ENTRIES];
  logic [INVACK_BITS-1:0] cnt_q [N_ENTRIES];
  logic [INVACK_BITS-1:0] cnt_d [N_ENTRIES];
  logic                   err_q, err_d;
  logic                   conflict;
  logic                   alloc_fire, done_fire, inv_masked;

  // Priority scans over registered state: lowest free slot, lowest set match, lowest pending completion
  always_comb begin
    alloc_idx_o  = '0;
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    done_valid_o = 1'b0;
    done_idx_o   = '0;
    mshr_cnt_o   = '0;
    conflict     = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx_o = IDX_W'(i);
      if (valid_q[i] && set_q[i] == lookup_set_i) begin
        lookup_hit_o = 1'b1;
        lookup_idx_o = IDX_W'(i);
      end
      if (valid_q[i] && cnt_q[i] == '0 && !rep_q[i]) begin
        done_valid_o = 1'b1;
        done_idx_o   = IDX_W'(i);
      end
      conflict   = conflict | (valid_q[i] && set_q[i] == alloc_set_i);
      mshr_cnt_o = mshr_cnt_o + CNT_W'(valid_q[i]);
    end
  end

  assign full_o        = mshr_cnt_o == CNT_W'(N_ENTRIES);
  assign empty_o       = mshr_cnt_o == '0;
  assign err_o         = err_q;
  assign done_req_id_o = done_valid_o ? id_q[done_idx_o] : '0;
  assign done_way_o    = done_valid_o ? way_q[done_idx_o] : '0;
`ifdef LLC_MSHR_CONFLICT_BLOCK_EN
  assign alloc_ready_o = !full_o && !conflict;
`else
  assign alloc_ready_o = !full_o;
`endif
  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  assign done_fire  = done_valid_o && done_ready_i;
  assign inv_masked = retire_valid_i && retire_idx_i == invack_idx_i;

  // Next state: completion accept, then inv-ack, then retire (wins over same-index inv-ack), then allocate
  always_comb begin
    valid_d = valid_q;
    rep_d   = rep_q;
    set_d   = set_q;
    tag_d   = tag_q;
    way_d   = way_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (done_fire) rep_d[done_idx_o] = 1'b1;
    if (invack_valid_i && !inv_masked) begin
      if (valid_q[invack_idx_i] && cnt_q[invack_idx_i] != '0) cnt_d[invack_idx_i] = cnt_q[invack_idx_i] - INVACK_BITS'(1);
      else err_d = 1'b1;
    end
    if (retire_valid_i) begin
      if (!valid_q[retire_idx_i]) err_d = 1'b1;
      valid_d[retire_idx_i] = 1'b0;
      rep_d[retire_idx_i]   = 1'b0;
    end
    if (alloc_fire) begin
      valid_d[alloc_idx_o] = 1'b1;
      rep_d[alloc_idx_o]   = 1'b0;
      set_d[alloc_idx_o]   = alloc_set_i;
      tag_d[alloc_idx_o]   = alloc_tag_i;
      way_d[alloc_idx_o]   = alloc_way_i;
      id_d[alloc_idx_o]    = alloc_req_id_i;
      cnt_d[alloc_idx_o]   = alloc_invack_cnt_i;
    end
  end

  // Table state register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      rep_q   <= '0;
      set_q   <= '{default: '0};
      tag_q   <= '{default: '0};
      way_q   <= '{default: '0};
      id_q    <= '{default: '0};
      cnt_q   <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rep_q   <= rep_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_llc_mshr_table.sv
// tb_llc_mshr_table: scoreboard bench for llc_mshr_table
module tb_llc_mshr_table;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       alloc_valid_i, alloc_ready_o;
  logic [8:0] alloc_set_i;
  logic [16:0] alloc_tag_i;
  logic [3:0] alloc_way_i, alloc_req_id_i, alloc_invack_cnt_i;
  logic [1:0] alloc_idx_o;
  logic [8:0] lookup_set_i;
  logic       lookup_hit_o;
  logic [1:0] lookup_idx_o;
  logic       invack_valid_i, retire_valid_i;
  logic [1:0] invack_idx_i, retire_idx_i;
  logic       done_valid_o, done_ready_i;
  logic [1:0] done_idx_o;
  logic [3:0] done_req_id_o, done_way_o;
  logic [2:0] mshr_cnt_o;
  logic       full_o, empty_o, err_o;

  typedef struct {int idx; int id; int way;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  llc_mshr_table dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_set_i(alloc_set_i), .alloc_tag_i(alloc_tag_i), .alloc_way_i(alloc_way_i),
    .alloc_req_id_i(alloc_req_id_i), .alloc_invack_cnt_i(alloc_invack_cnt_i), .alloc_idx_o(alloc_idx_o),
    .lookup_set_i(lookup_set_i), .lookup_hit_o(lookup_hit_o), .lookup_idx_o(lookup_idx_o),
    .invack_valid_i(invack_valid_i), .invack_idx_i(invack_idx_i),
    .retire_valid_i(retire_valid_i), .retire_idx_i(retire_idx_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_idx_o(done_idx_o),
    .done_req_id_o(done_req_id_o), .done_way_o(done_way_o),
    .mshr_cnt_o(mshr_cnt_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [8:0] s, input logic [3:0] w, input logic [3:0] id, input logic [3:0] c);
    alloc_valid_i = 1'b1;
    alloc_set_i = s;
    alloc_tag_i = 17'(s) + 17'h5;
    alloc_way_i = w;
    alloc_req_id_i = id;
    alloc_invack_cnt_i = c;
  endtask

  task automatic idle;
    alloc_valid_i = 1'b0;
    invack_valid_i = 1'b0;
    retire_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_ready"}, alloc_ready_o, 1);
    check({t, "_aidx"}, alloc_idx_o, 0);
    check({t, "_hit"}, lookup_hit_o, 0);
    check({t, "_lidx"}, lookup_idx_o, 0);
    check({t, "_dv"}, done_valid_o, 0);
    check({t, "_didx"}, done_idx_o, 0);
    check({t, "_did"}, done_req_id_o, 0);
    check({t, "_dway"}, done_way_o, 0);
    check({t, "_cnt"}, mshr_cnt_o, 0);
    check({t, "_full"}, full_o, 0);
    check({t, "_empty"}, empty_o, 1);
    check({t, "_err"}, err_o, 0);
  endtask

  // Completion monitor: every accepted completion must match the oldest expectation
  always @(negedge clk_i) begin
    if (rst_ni && done_valid_o && done_ready_i) begin
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_idx", done_idx_o, e.idx);
        check("sb_id", done_req_id_o, e.id);
        check("sb_way", done_way_o, e.way);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    idle();
    done_ready_i = 1'b0;
    alloc_set_i = '0; alloc_tag_i = '0; alloc_way_i = '0; alloc_req_id_i = '0; alloc_invack_cnt_i = '0;
    lookup_set_i = '0; invack_idx_i = '0; retire_idx_i = '0;
    tick();
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    tick();
    // basic allocate / two inv-acks / accept / retire
    alloc(9'h12, 4'd3, 4'd2, 4'd2);
    #1 check("t1_aidx", alloc_idx_o, 0);
    tick(); idle();
    lookup_set_i = 9'h12;
    #1 check("t1_cnt", mshr_cnt_o, 1);
    check("t1_hit", lookup_hit_o, 1);
    check("t1_lidx", lookup_idx_o, 0);
    check("t1_dv0", done_valid_o, 0);
    lookup_set_i = 9'h13;
    #1 check("t1_miss", lookup_hit_o, 0);
    invack_valid_i = 1'b1; invack_idx_i = 0;
    tick();
    check("t1_dv1", done_valid_o, 0);
    sb.push_back('{0, 2, 3});
    tick(); idle();
    check("t1_dv2", done_valid_o, 1);
    check("t1_did", done_req_id_o, 2);
    check("t1_dway", done_way_o, 3);
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    check("t1_dv3", done_valid_o, 0);
    check("t1_stay", mshr_cnt_o, 1);
    retire_valid_i = 1'b1; retire_idx_i = 0;
    tick(); idle();
    check("t1_empty", empty_o, 1);
    check("t1_err", err_o, 0);
    // zero-count allocation: done next cycle, held stable without ready
    alloc(9'h30, 4'd7, 4'd5, 4'd0);
    tick(); idle();
    check("hold_dv", done_valid_o, 1);
    tick();
    check("hold_dv2", done_valid_o, 1);
    check("hold_id", done_req_id_o, 5);
    check("hold_way", done_way_o, 7);
    retire_valid_i = 1'b1; retire_idx_i = 0;
    tick(); idle();
    check("ret_pend_dv", done_valid_o, 0);
    // fill all entries with zero counts, drain completions in order
    for (int i = 0; i < 4; i++) begin
      alloc(9'(9'h100 + i), 4'(i), 4'(i + 1), 4'd0);
      #1 check("fill_aidx", alloc_idx_o, i);
      tick();
    end
    idle();
    check("fill_full", full_o, 1);
    check("fill_ready", alloc_ready_o, 0);
    check("fill_cnt", mshr_cnt_o, 4);
    for (int i = 0; i < 4; i++) sb.push_back('{i, i + 1, i});
    done_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_idx", done_idx_o, i);
      tick();
    end
    done_ready_i = 1'b0;
    check("drain_dv", done_valid_o, 0);
    // alloc while full is refused even with a simultaneous retire
    alloc(9'h1a0, 4'd1, 4'd9, 4'd1);
    retire_valid_i = 1'b1; retire_idx_i = 1;
    tick(); idle();
    check("full_ret_cnt", mshr_cnt_o, 3);
    check("full_ret_aidx", alloc_idx_o, 1);
    check("full_ret_ready", alloc_ready_o, 1);
    alloc(9'h1a0, 4'd1, 4'd9, 4'd1);
    retire_valid_i = 1'b1; retire_idx_i = 2;
    tick(); idle();
    check("swap_cnt", mshr_cnt_o, 3);
    check("swap_aidx", alloc_idx_o, 2);
    check("swap_err", err_o, 0);
    invack_valid_i = 1'b1; invack_idx_i = 1;
    retire_valid_i = 1'b1; retire_idx_i = 1;
    tick(); idle();
    check("inv_ret_err", err_o, 0);
    check("inv_ret_cnt", mshr_cnt_o, 2);
    // protocol errors
    invack_valid_i = 1'b1; invack_idx_i = 0;
    tick(); idle();
    check("inv0_err", err_o, 1);
    check("inv0_cnt", mshr_cnt_o, 2);
    check("inv0_dv", done_valid_o, 0);
    retire_valid_i = 1'b1; retire_idx_i = 1;
    tick(); idle();
    check("retinv_err", err_o, 1);
    check("retinv_cnt", mshr_cnt_o, 2);
    tick();
    check("err_sticky", err_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst2_err", err_o, 0);
    // inv-ack to the slot being allocated: error, count unmodified
    alloc(9'h40, 4'd6, 4'd4, 4'd2);
    invack_valid_i = 1'b1; invack_idx_i = 0;
    tick(); idle();
    check("ia_err", err_o, 1);
    check("ia_dv", done_valid_o, 0);
    invack_valid_i = 1'b1; invack_idx_i = 0;
    tick(); idle();
    check("ia_dv1", done_valid_o, 0);
    invack_valid_i = 1'b1; invack_idx_i = 0;
    sb.push_back('{0, 4, 6});
    tick(); idle();
    check("ia_dv2", done_valid_o, 1);
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    // set conflict blocking
    alloc_set_i = 9'h40;
    #1;
`ifdef LLC_MSHR_CONFLICT_BLOCK_EN
    check("cf_same", alloc_ready_o, 0);
`else
    check("cf_same", alloc_ready_o, 1);
`endif
    alloc_set_i = 9'h41;
    #1 check("cf_other", alloc_ready_o, 1);
    alloc(9'h40, 4'd2, 4'd1, 4'd3);
    tick(); idle();
`ifdef LLC_MSHR_CONFLICT_BLOCK_EN
    check("cf_cnt", mshr_cnt_o, 1);
`else
    check("cf_cnt", mshr_cnt_o, 2);
`endif
    // asynchronous reset with pending completions
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      alloc(9'(9'h200 + i), 4'(i), 4'(i), 4'd0);
      tick();
    end
    idle();
    check("pre_rst_cnt", mshr_cnt_o, 3);
    check("pre_rst_dv", done_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("arst");
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_empty", empty_o, 1);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
